// File: rtl/lift_buf_pkg.sv
// Shared definitions for the ping-pong lift input buffer: default geometry,
// drain FSM encoding and the per-batch channel-count selection.
package lift_buf_pkg;

    localparam int W_DEF     = 30;
    localparam int NCH_DEF   = 8;
    localparam int CH_Q_DEF  = 6;
    localparam int DEPTH_DEF = 32;

    localparam logic MODE_Q    = 1'b0;
    localparam logic MODE_BIGQ = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LAST  = 2'd2
    } drain_state_e;

    // Number of residues drained per coefficient for a batch latched with this mode.
    function automatic int chan_count(input logic mode, input int nch, input int ch_q);
        case (mode)
            MODE_Q:    return ch_q;
            MODE_BIGQ: return nch;
            default:   return nch;
        endcase
    endfunction

endpackage

// File: rtl/lift_pingpong_bank_ram.sv
// Two-bank distributed RAM: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module lift_pingpong_bank_ram #(
    parameter int DW    = 240,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_word
);

    logic [DW-1:0] mem_r [2][DEPTH];

    // Host write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_word = mem_r[rd_bank][rd_addr];

endmodule

// File: rtl/lift_pingpong_input_buffer.sv
// Double-buffered lift input buffer: the host fills one bank while the other
// is streamed out one residue per beat under valid/ready flow control.
module lift_pingpong_input_buffer
    import lift_buf_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int NCH   = NCH_DEF,
    parameter int CH_Q  = CH_Q_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    top_address,
    input  logic             we,
    input  logic [NCH*W-1:0] din,
    input  logic             commit,
    input  logic             mode,
    output logic             host_ready,
    output logic             commit_err,
    output logic [W-1:0]     rd_data,
    output logic [AW-1:0]    rd_addr,
    output logic [CW-1:0]    rd_bank,
    output logic             rd_last,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             done
);

    localparam int RAW = $clog2(DEPTH);
    localparam int DW  = NCH * W;

    drain_state_e  state_r, state_n;
    logic [1:0]    full_r, full_n;
    logic [1:0]    mode_b_r;
    logic          fill_ptr_r, fill_ptr_n;
    logic          drain_ptr_r, drain_ptr_n;
    logic [AW-1:0] addr_cnt_r;
    logic [CW-1:0] ch_cnt_r;

    logic [W-1:0]  rd_data_r;
    logic [AW-1:0] rd_addr_r;
    logic [CW-1:0] rd_bank_r;
    logic          rd_last_r, rd_valid_r, done_r, commit_err_r, host_ready_r;

    logic          fill_free_s, addr_ok_s, wr_en_s, commit_ok_s;
    logic          start_s, load_s, release_s, load_en_s, beat_last_s;
    logic [CW-1:0] last_ch_s;
    logic [DW-1:0] rd_word_s;

    lift_pingpong_bank_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (RAW)
    ) u_ram (
        .clk     (clk),
        .we      (wr_en_s),
        .wr_bank (fill_ptr_r),
        .wr_addr (top_address[RAW-1:0]),
        .wr_data (din),
        .rd_bank (drain_ptr_r),
        .rd_addr (addr_cnt_r[RAW-1:0]),
        .rd_word (rd_word_s)
    );

    // Host-side qualifiers and current-beat decode.
    always_comb begin
        fill_free_s = !full_r[fill_ptr_r];
        addr_ok_s   = (32'(top_address) < 32'(DEPTH));
        wr_en_s     = we && fill_free_s && addr_ok_s;
        commit_ok_s = commit && fill_free_s;
        last_ch_s   = CW'(chan_count(mode_b_r[drain_ptr_r], NCH, CH_Q) - 32'sd1);
        beat_last_s = (addr_cnt_r == AW'(DEPTH - 1)) && (ch_cnt_r == last_ch_s);
        load_en_s   = !rd_valid_r || rd_ready;
    end

    // Drain FSM next state and per-cycle strobes.
    always_comb begin
        state_n   = state_r;
        start_s   = 1'b0;
        load_s    = 1'b0;
        release_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (full_r[drain_ptr_r]) begin
                    state_n = ST_DRAIN;
                    start_s = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (load_en_s) begin
                    load_s  = 1'b1;
                    state_n = beat_last_s ? ST_LAST : ST_DRAIN;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            ST_LAST: begin
                if (rd_ready) begin
                    release_s = 1'b1;
                    state_n   = ST_IDLE;
                end else begin
                    state_n = ST_LAST;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Bank ownership: commit and release always touch different banks.
    always_comb begin
        full_n      = full_r;
        fill_ptr_n  = fill_ptr_r;
        drain_ptr_n = drain_ptr_r;
        if (commit_ok_s) begin
            full_n[fill_ptr_r] = 1'b1;
            fill_ptr_n         = !fill_ptr_r;
        end else begin
            fill_ptr_n = fill_ptr_r;
        end
        if (release_s) begin
            full_n[drain_ptr_r] = 1'b0;
            drain_ptr_n         = !drain_ptr_r;
        end else begin
            drain_ptr_n = drain_ptr_r;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Bank flags, pointers and host-side status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r       <= 2'b00;
            mode_b_r     <= 2'b00;
            fill_ptr_r   <= 1'b0;
            drain_ptr_r  <= 1'b0;
            host_ready_r <= 1'b1;
            commit_err_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            full_r       <= full_n;
            fill_ptr_r   <= fill_ptr_n;
            drain_ptr_r  <= drain_ptr_n;
            host_ready_r <= !full_n[fill_ptr_n];
            commit_err_r <= commit && !fill_free_s;
            done_r       <= release_s;
            if (commit_ok_s) begin
                mode_b_r[fill_ptr_r] <= mode;
            end
        end
    end

    // Address-major, channel-minor counters and the output beat register.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt_r <= {AW{1'b0}};
            ch_cnt_r   <= {CW{1'b0}};
            rd_data_r  <= {W{1'b0}};
            rd_addr_r  <= {AW{1'b0}};
            rd_bank_r  <= {CW{1'b0}};
            rd_last_r  <= 1'b0;
            rd_valid_r <= 1'b0;
        end else if (start_s) begin
            addr_cnt_r <= {AW{1'b0}};
            ch_cnt_r   <= {CW{1'b0}};
        end else if (load_s) begin
            rd_data_r  <= rd_word_s[int'(ch_cnt_r) * W +: W];
            rd_addr_r  <= addr_cnt_r;
            rd_bank_r  <= ch_cnt_r;
            rd_last_r  <= beat_last_s;
            rd_valid_r <= 1'b1;
            if (ch_cnt_r == last_ch_s) begin
                ch_cnt_r   <= {CW{1'b0}};
                addr_cnt_r <= addr_cnt_r + AW'(1'b1);
            end else begin
                ch_cnt_r <= ch_cnt_r + CW'(1'b1);
            end
        end else if (release_s) begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
        end
    end

    assign host_ready = host_ready_r;
    assign commit_err = commit_err_r;
    assign rd_data    = rd_data_r;
    assign rd_addr    = rd_addr_r;
    assign rd_bank    = rd_bank_r;
    assign rd_last    = rd_last_r;
    assign rd_valid   = rd_valid_r;
    assign done       = done_r;

endmodule

// File: tb/tb_lift_pingpong_input_buffer.sv
// Scoreboard bench for the ping-pong lift input buffer (DEPTH=32, AW=6).
// Beats are queued when a batch is committed; a negedge monitor pops and compares.
module tb_lift_pingpong_input_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   top_address;
    logic         we;
    logic [239:0] din;
    logic         commit;
    logic         mode;
    logic         host_ready;
    logic         commit_err;
    logic [29:0]  rd_data;
    logic [5:0]   rd_addr;
    logic [2:0]   rd_bank;
    logic         rd_last;
    logic         rd_valid;
    logic         rd_ready;
    logic         done;

    lift_pingpong_input_buffer #(
        .W(30), .NCH(8), .CH_Q(6), .DEPTH(32), .AW(6), .CW(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .top_address (top_address),
        .we          (we),
        .din         (din),
        .commit      (commit),
        .mode        (mode),
        .host_ready  (host_ready),
        .commit_err  (commit_err),
        .rd_data     (rd_data),
        .rd_addr     (rd_addr),
        .rd_bank     (rd_bank),
        .rd_last     (rd_last),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .done        (done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_seen = 0;
    int          acc_cnt = 0;
    int          cyc = 0;
    int          done_cyc = 0;
    int          last_gap = -1;
    bit          watch_first = 1'b0;
    int          ready_mode = 0;
    logic [39:0] exp_q [$];
    logic [39:0] last_beat = 40'd0;
    logic [39:0] held_beat;
    logic [39:0] cur_beat;
    logic [39:0] exp_beat;
    bit          held_v = 1'b0;
    int unsigned model_mem [2][32][8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int bank, input int base);
        for (int a = 0; a < 32; a++) begin
            for (int c = 0; c < 8; c++) begin
                din[c*30 +: 30] = 30'(base + 1000 * a + c);
                model_mem[bank][a][c] = base + 1000 * a + c;
            end
            top_address = 6'(a);
            we = 1'b1;
            tick();
        end
        we = 1'b0;
    endtask

    // A write that the DUT must drop; the model is left untouched.
    task automatic junk_write(input int addr);
        for (int c = 0; c < 8; c++) din[c*30 +: 30] = 30'h2AAA_AAAA;
        top_address = 6'(addr);
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic push_batch(input int bank, input logic m);
        int nch;
        nch = m ? 8 : 6;
        for (int a = 0; a < 32; a++)
            for (int c = 0; c < nch; c++)
                exp_q.push_back({(a == 31 && c == nch - 1), 3'(c), 6'(a), 30'(model_mem[bank][a][c])});
    endtask

    task automatic do_commit(input logic m);
        mode = m;
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_seen < target && n < budget) begin
            tick();
            n++;
        end
        chk("done_within_budget", 64'(done_seen >= target), 64'd1);
    endtask

    // rd_ready driver: always-on or 30% random duty.
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rd_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
        end
    end

    // Monitor: stall stability, done pulses, bubble gap and scoreboard pops.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                held_v = 1'b0;
            end else begin
                cur_beat = {rd_last, rd_bank, rd_addr, rd_data};
                if (held_v) chk("stall_hold", {rd_valid, cur_beat}, {1'b1, held_beat});
                if (done) begin
                    done_seen++;
                    done_cyc = cyc;
                    watch_first = 1'b1;
                end else if (rd_valid && watch_first) begin
                    last_gap = cyc - done_cyc;
                    watch_first = 1'b0;
                end
                if (rd_valid && rd_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL beat_unexpected: got 0x%0h expected none", cur_beat);
                    end else begin
                        exp_beat = exp_q.pop_front();
                        chk("beat", 64'(cur_beat), 64'(exp_beat));
                        last_beat = cur_beat;
                    end
                    acc_cnt++;
                    held_v = 1'b0;
                end else if (rd_valid) begin
                    held_v = 1'b1;
                    held_beat = cur_beat;
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int acc0;
        int n;
        rst = 1'b1; top_address = 6'd0; we = 1'b0; din = '0; commit = 1'b0; mode = 1'b0;
        repeat (3) tick();
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_host_ready", host_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_commit_err", commit_err, 1'b0);
        chk("rst_rd_outputs", {rd_last, rd_bank, rd_addr, rd_data}, 40'd0);
        rst = 1'b0;
        tick();

        // Q-lift batch from bank0: 256 beats, latency 2 after commit edge.
        fill(0, 0);
        push_batch(0, 1'b1);
        do_commit(1'b1);
        chk("host_ready_after_commit", host_ready, 1'b1);
        chk("latency_cycle1", rd_valid, 1'b0);
        tick();
        chk("latency_cycle2", rd_valid, 1'b0);
        tick();
        chk("latency_cycle3", rd_valid, 1'b1);
        wait_done(1, 2000);
        repeat (3) tick();
        chk("done_count_a", done_seen, 1);
        chk("queue_empty_a", exp_q.size(), 0);
        chk("last_beat_a", last_beat, {1'b1, 3'd7, 6'd31, 30'd31007});

        // q-lift batch from bank1: 192 beats, channels 0..5.
        fill(1, 0);
        push_batch(1, 1'b0);
        do_commit(1'b0);
        wait_done(2, 2000);
        repeat (3) tick();
        chk("done_count_b", done_seen, 2);
        chk("queue_empty_b", exp_q.size(), 0);
        chk("last_beat_b", last_beat, {1'b1, 3'd5, 6'd31, 30'd31005});

        // Overlapped fill, rejected third commit, dropped writes, 30% ready duty.
        ready_mode = 1;
        fill(0, 50000);
        push_batch(0, 1'b1);
        do_commit(1'b1);
        fill(1, 70000);
        junk_write(40);
        push_batch(1, 1'b0);
        do_commit(1'b0);
        chk("host_ready_both_full", host_ready, 1'b0);
        junk_write(20);
        do_commit(1'b1);
        chk("commit_err_pulse", commit_err, 1'b1);
        tick();
        chk("commit_err_single", commit_err, 1'b0);
        chk("host_ready_still_busy", host_ready, 1'b0);
        wait_done(3, 5000);
        repeat (3) tick();
        chk("bubble_gap", last_gap, 2);
        wait_done(4, 5000);
        repeat (3) tick();
        chk("done_count_c", done_seen, 4);
        chk("queue_empty_c", exp_q.size(), 0);
        ready_mode = 0;
        tick();

        // Reset in the middle of a drain.
        fill(0, 20000);
        push_batch(0, 1'b1);
        do_commit(1'b1);
        acc0 = acc_cnt;
        n = 0;
        while (acc_cnt < acc0 + 100 && n < 1000) begin
            tick();
            n++;
        end
        chk("reached_beat_100", 64'(acc_cnt >= acc0 + 100), 64'd1);
        d = done_seen;
        rst = 1'b1;
        tick();
        chk("midrst_rd_valid", rd_valid, 1'b0);
        chk("midrst_host_ready", host_ready, 1'b1);
        rst = 1'b0;
        exp_q.delete();
        repeat (6) tick();
        chk("midrst_no_done", done_seen, d);
        chk("midrst_stays_idle", rd_valid, 1'b0);

        fill(0, 40000);
        push_batch(0, 1'b0);
        do_commit(1'b0);
        wait_done(d + 1, 2000);
        repeat (3) tick();
        chk("done_count_e", done_seen, d + 1);
        chk("queue_empty_e", exp_q.size(), 0);
        chk("last_beat_e", last_beat, {1'b1, 3'd5, 6'd31, 30'd71005});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
